// File: rtl/bcd_to_bin32.sv
// rtl/bcd_to_bin32.sv - sequential BCD-to-binary converter (reverse double dabble), optional sign via BCD_SIGNED_EN
module bcd_to_bin32 #(
    parameter int DIGITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] bcd_in,
    input  logic        neg,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] bin_out
);

    // Number of shift iterations and the alignment of the finished result
    localparam int          NBITS = 4 * DIGITS;
    localparam int          ALIGN = 32 - NBITS;
    localparam logic [5:0]  LAST  = 6'(NBITS - 1);
    localparam logic [31:0] MASK  = (DIGITS >= 8) ? 32'hFFFF_FFFF
                                                  : ((32'd1 << NBITS) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t      state;
    logic [63:0] shift_reg;
    logic [5:0]  count;

    logic [63:0] shift_next;
    logic        digits_ok;
    logic [31:0] result;

`ifdef BCD_SIGNED_EN
    logic        sign;
`else
    // The sign request has no effect in the unsigned build
    logic        unused_neg;
    assign unused_neg = neg;
`endif

    // Reject the word if any digit in use is A..F (bit3 set with bit2 or bit1 set)
    always_comb begin
        digits_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_in[4*k+3] && (bcd_in[4*k+2] || bcd_in[4*k+1])) begin
                digits_ok = 1'b0;
            end
        end
    end

    // One reverse double dabble step: shift right, then pull 3 out of any nibble that reached 8+
    always_comb begin
        shift_next = shift_reg >> 1;
        for (int k = 0; k < DIGITS; k++) begin
            if (shift_next[32+4*k+3]) begin
                shift_next[32+4*k +: 4] = shift_next[32+4*k +: 4] - 4'd3;
            end
        end
    end

    // Finished binary value sits MSB-first at the top of the low half
    assign result = shift_reg[31:0] >> ALIGN;

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bin_out   <= '0;
`ifdef BCD_SIGNED_EN
            sign      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (digits_ok) begin
                            shift_reg <= {bcd_in & MASK, 32'd0};
                            count     <= '0;
                            busy      <= 1'b1;
                            state     <= SHIFT;
`ifdef BCD_SIGNED_EN
                            sign      <= neg;
`endif
                        end else begin
                            // Bad digit: report immediately, keep the previous result
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_next;
                    count     <= count + 6'd1;
                    if (count == LAST) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
`ifdef BCD_SIGNED_EN
                    // Two's-complement negate; zero stays zero
                    bin_out <= sign ? (~result + 32'd1) : result;
`else
                    bin_out <= result;
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin32.sv
// tb/tb_bcd_to_bin32.sv - randomized self-checking bench for bcd_to_bin32
module tb_bcd_to_bin32;

    localparam int DIGITS = 8;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] bcd_in;
    logic        neg;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] bin_out;

    int          n_checks;
    int          n_pass;
    logic [31:0] last_bin;

    bcd_to_bin32 #(.DIGITS(DIGITS)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .bcd_in  (bcd_in),
        .neg     (neg),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit model_valid(input logic [31:0] bcd);
        for (int i = 0; i < DIGITS; i++) begin
            if (((bcd >> (4 * i)) & 32'hF) > 9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_value(input logic [31:0] bcd, input logic n);
        longint v;
        longint p;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            v = v + longint'((bcd >> (4 * i)) & 32'hF) * p;
            p = p * 10;
        end
`ifdef BCD_SIGNED_EN
        if (n) v = -v;
`else
        if (n) v = v;
`endif
        return v[31:0];
    endfunction

    // Wait for done at falling edges; cycles counts falling edges elapsed
    task automatic wait_done(output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (!ok && cycles < 200) begin
            @(negedge clock);
            cycles++;
            if (done) ok = 1'b1;
        end
    endtask

    // Single start pulse; checks result, error flag, latency and busy length
    task automatic do_conv(input string tag, input logic [31:0] bcd, input logic n);
        int   k;
        int   busy_cycles;
        bit   seen;
        bit   bad;
        logic [31:0] exp;
        bad = !model_valid(bcd);
        exp = bad ? last_bin : model_value(bcd, n);
        bcd_in = bcd;
        neg    = n;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 1;
        busy_cycles = 0;
        seen = 1'b0;
        while (!seen && k < 200) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                @(negedge clock);
                k++;
            end
        end
        check({tag, ".done"}, 32'(seen), 32'd1);
        check({tag, ".err"}, 32'(err), 32'(bad));
        check({tag, ".bin"}, bin_out, exp);
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        if (bad) begin
            check({tag, ".err_latency"}, 32'(k - 1), 32'd0);
        end else begin
            check({tag, ".latency"}, 32'(k - 1), 32'(4 * DIGITS + 1));
            check({tag, ".busy_len"}, 32'(busy_cycles), 32'(4 * DIGITS + 1));
            last_bin = exp;
        end
        @(negedge clock);
        check({tag, ".pulse"}, 32'({done, err}), 32'd0);
    endtask

    initial begin
        int          cyc;
        bit          ok;
        int          dcount;
        logic [31:0] b;
        logic        nn;

        n_checks = 0;
        n_pass   = 0;
        last_bin = 32'd0;
        reset    = 1'b1;
        start    = 1'b0;
        bcd_in   = 32'd0;
        neg      = 1'b0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.bin", bin_out, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        do_conv("d1234", 32'h1234_5678, 1'b0);
        check("d1234.value", bin_out, 32'h00BC_614E);
        do_conv("dbad", 32'h0000_001A, 1'b0);
        check("dbad.keep", bin_out, 32'h00BC_614E);
        do_conv("d9999", 32'h9999_9999, 1'b0);
        check("d9999.value", bin_out, 32'h05F5_E0FF);
        do_conv("dzero", 32'h0000_0000, 1'b1);
        check("dzero.value", bin_out, 32'h0000_0000);
        do_conv("d42n", 32'h0000_0042, 1'b1);
`ifdef BCD_SIGNED_EN
        check("d42n.value", bin_out, 32'hFFFF_FFD6);
`else
        check("d42n.value", bin_out, 32'h0000_002A);
`endif

        // start re-pulsed mid-conversion must be ignored
        bcd_in = 32'h1234_5678;
        neg    = 1'b0;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        bcd_in = 32'h0000_0001;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(cyc, ok);
        check("ign.done", 32'(ok), 32'd1);
        check("ign.bin", bin_out, 32'h00BC_614E);
        last_bin = 32'h00BC_614E;
        dcount = 0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) dcount++;
        end
        check("ign.not_queued", 32'(dcount), 32'd0);

        // start held high: next conversion captured in the done cycle
        bcd_in = 32'h0000_0250;
        start  = 1'b1;
        wait_done(cyc, ok);
        check("held1.done", 32'(ok), 32'd1);
        check("held1.bin", bin_out, 32'd250);
        bcd_in = 32'h0009_8765;
        wait_done(cyc, ok);
        start = 1'b0;
        check("held2.done", 32'(ok), 32'd1);
        check("held2.period", 32'(cyc), 32'(4 * DIGITS + 2));
        check("held2.bin", bin_out, 32'd98765);
        last_bin = 32'd98765;
        @(negedge clock);

        // reset mid-conversion aborts without a done pulse
        bcd_in = 32'h1234_5678;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rmid.busy", 32'(busy), 32'd0);
        check("rmid.done", 32'(done), 32'd0);
        check("rmid.bin", bin_out, 32'd0);
        last_bin = 32'd0;
        dcount = 0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) dcount++;
        end
        check("rmid.quiet", 32'(dcount), 32'd0);
        do_conv("rmid7", 32'h0000_0007, 1'b0);
        check("rmid7.value", bin_out, 32'd7);

        // Randomized conversions, some with an injected bad digit
        for (int t = 0; t < 24; t++) begin
            b = 32'd0;
            for (int i = 0; i < DIGITS; i++) begin
                b = b | (32'($urandom_range(0, 9)) << (4 * i));
            end
            if ($urandom_range(0, 5) == 0) begin
                int pos;
                pos = $urandom_range(0, DIGITS - 1);
                b = (b & ~(32'hF << (4 * pos))) | (32'($urandom_range(10, 15)) << (4 * pos));
            end
            nn = 1'($urandom_range(0, 1));
            do_conv($sformatf("rnd%0d", t), b, nn);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
